// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC, FSM states and the
// bit positions of the instruction fields presented to the control unit.
package instr_fetch_unit_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 28;
    localparam int unsigned F_MSB      = 27;
    localparam int unsigned F_LSB      = 24;
    localparam int unsigned RD_MSB     = 23;
    localparam int unsigned RD_LSB     = 20;
    localparam int unsigned RN_MSB     = 19;
    localparam int unsigned RN_LSB     = 16;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2,
        S_WAIT    = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } queue_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Two-entry FIFO of fetched {instr, pc}; entry0 is always the head.
// Flush wins over push/pop; push+pop together keeps the count unchanged.
module instr_queue
    import instr_fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic [PC_W-1:0]    push_pc_i,
    output logic [1:0]         count_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [PC_W-1:0]    head_pc_o
);

    queue_entry_t entry0_q, entry0_d;
    queue_entry_t entry1_q, entry1_d;
    logic [1:0]   count_q, count_d;
    queue_entry_t push_entry;

    assign push_entry = '{instr: push_instr_i, pc: push_pc_i};

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry0_d = push_entry;
                    end else begin
                        entry1_d = push_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    // With one entry the pushed word becomes the new head directly.
                    if (count_q == 2'd1) begin
                        entry0_d = push_entry;
                    end else begin
                        entry0_d = entry1_q;
                        entry1_d = push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_instr_o = entry0_q.instr;
    assign head_pc_o    = entry0_q.pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, buffers results in a
// two-entry queue and redirects on taken jumps, discarding any in-flight stale read.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = instr_fetch_unit_pkg::RESET_PC,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               salto,
    input  logic [PC_W-1:0]    salto_target,
    output logic               instr_valid,
    output logic [3:0]         opcode,
    output logic [3:0]         f,
    output logic [3:0]         rd,
    output logic [3:0]         rn,
    output logic [15:0]        imm,
    output logic [PC_W-1:0]    pc_out
);

    localparam logic [1:0] QFULL = 2'(QDEPTH);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    disc_addr_q, disc_addr_d;

    logic               push, pop, flush, salto_taken;
    logic [1:0]         count;
    logic [1:0]         count_after_push;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_pc;

    instr_queue u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (flush),
        .push_instr_i (imem_rdata),
        .push_pc_i    (pc_q),
        .count_o      (count),
        .head_instr_o (head_instr),
        .head_pc_o    (head_pc)
    );

    assign instr_valid      = (count != 2'd0);
    assign pop              = instr_valid && !stall;
    assign salto_taken      = salto && pop;
    assign flush            = salto_taken;
    assign count_after_push = count + 2'd1 - {1'b0, pop};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        push        = 1'b0;
        imem_req    = 1'b0;
        imem_addr   = '0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (salto_taken) begin
                    pc_d = salto_target;
                    // Without an ack the read stays in flight and its data must be dropped.
                    if (!imem_ack) begin
                        state_d     = S_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end else if (imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + 1'b1;
                    if (count_after_push >= QFULL) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (salto_taken) begin
                    pc_d    = salto_target;
                    state_d = S_REQ;
                end else if (count < QFULL) begin
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = disc_addr_q;
                if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            disc_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    // Stale entries left behind by a flush never leak onto the decode fields.
    assign opcode = instr_valid ? head_instr[OPCODE_MSB:OPCODE_LSB] : '0;
    assign f      = instr_valid ? head_instr[F_MSB:F_LSB]           : '0;
    assign rd     = instr_valid ? head_instr[RD_MSB:RD_LSB]         : '0;
    assign rn     = instr_valid ? head_instr[RN_MSB:RN_LSB]         : '0;
    assign imm    = instr_valid ? head_instr[IMM_MSB:IMM_LSB]       : '0;
    assign pc_out = instr_valid ? head_pc                           : '0;

endmodule
